// File: rtl/m4_mem_pkg.sv
// Shared types and constants for the M4 SRAM write-path merge stage.
package m4_mem_pkg;

  localparam int unsigned M4_AW    = 19;
  localparam int unsigned M4_DW    = 32;
  localparam logic [3:0]  DQM_NONE = 4'hF;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    SWITCH = 2'd1,
    NORMAL = 2'd2
  } wmux_state_e;

  typedef struct packed {
    logic              bank1;
    logic [M4_AW-1:0]  wad;
    logic [3:0]        dqm;
    logic [M4_DW-1:0]  wdata;
  } m4_went_t;

endpackage

// File: rtl/m4_mem_wmux_xt_wfifo.sv
// Register-based synchronous FIFO holding buffered normal write entries.
module m4_wfifo_xt
  import m4_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = $bits(m4_went_t)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  // Full is taken from the registered count, so a pop never opens room for a same-clk push.
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/m4_mem_wmux_xt.sv
// Merges the power-up clear write stream and buffered normal writes onto the SRAM write port.
// Optional stall_cnt output is built when M4_WMUX_STALL_CNT_EN is defined.
module m4_mem_wmux_xt
  import m4_mem_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = M4_AW,
  parameter int unsigned DW         = M4_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m4_cmd_cycle_stp,
  input  logic          m4_cmd_cycle,
  input  logic [AW-1:0] clr_wad,
  input  logic          clr_wr_bank1,
  input  logic          clr_we,
  input  logic [3:0]    clr_dqm,
  input  logic [DW-1:0] clr_wdata,
  input  logic          mem_clear_done,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_wad,
  input  logic          req_bank1,
  input  logic [3:0]    req_dqm,
  input  logic [DW-1:0] req_wdata,
  output logic [AW-1:0] sram_wad,
  output logic          sram_wr_bank1,
  output logic          sram_we,
  output logic [3:0]    sram_dqm,
  output logic [DW-1:0] sram_wdata,
  output logic          clr_busy
`ifdef M4_WMUX_STALL_CNT_EN
  ,
  output logic [7:0]    stall_cnt
`endif
);

  typedef struct packed {
    logic          bank1;
    logic [AW-1:0] wad;
    logic [3:0]    dqm;
    logic [DW-1:0] wdata;
  } went_t;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  wmux_state_e   state_q, state_d;
  went_t         slot_q, req_ent, fifo_head;
  logic          slot_valid_q;
  logic [AW-1:0] sram_wad_q;
  logic          sram_bank1_q, sram_we_q;
  logic [3:0]    sram_dqm_q;
  logic [DW-1:0] sram_wdata_q;
  logic          fifo_full, fifo_empty, fifo_pop, clr_path;
  logic [CW-1:0] fifo_cnt;

  assign req_ent  = '{bank1: req_bank1, wad: req_wad, dqm: req_dqm, wdata: req_wdata};
  assign req_ready = ~fifo_full;
  assign fifo_pop  = (state_q == NORMAL) & mem_clear_done & m4_cmd_cycle_stp;
  // Losing mem_clear_done switches to the clear path on the same edge the state returns to CLEAR.
  assign clr_path  = (state_q == CLEAR) | ~mem_clear_done;

  m4_wfifo_xt #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(went_t))
  ) u_wfifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid),
    .pop_i   (fifo_pop),
    .wdata_i (req_ent),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  a_fifo_flags: assert property (@(posedge clk) disable iff (rst)
    (fifo_full == (fifo_cnt == FULL_CNT)) && (fifo_empty == (fifo_cnt == '0)));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (mem_clear_done) state_d = SWITCH;
      SWITCH:  if (!mem_clear_done) state_d = CLEAR;
               else if (m4_cmd_cycle_stp) state_d = NORMAL;
      NORMAL:  if (!mem_clear_done) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      slot_valid_q <= 1'b0;
      slot_q       <= '{bank1: 1'b0, wad: '0, dqm: DQM_NONE, wdata: '0};
      sram_wad_q   <= '0;
      sram_bank1_q <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_dqm_q   <= DQM_NONE;
      sram_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (clr_path) begin
        slot_valid_q <= 1'b0;
        sram_wad_q   <= clr_wad;
        sram_bank1_q <= clr_wr_bank1;
        sram_we_q    <= clr_we;
        sram_dqm_q   <= clr_dqm;
        sram_wdata_q <= clr_wdata;
      end else if (state_q == SWITCH) begin
        slot_valid_q <= 1'b0;
        sram_we_q    <= 1'b0;
        sram_dqm_q   <= DQM_NONE;
      end else begin
        if (m4_cmd_cycle_stp) begin
          slot_valid_q <= ~fifo_empty;
          if (!fifo_empty) slot_q <= fifo_head;
        end
        sram_wad_q   <= slot_q.wad;
        sram_bank1_q <= slot_q.bank1;
        sram_dqm_q   <= slot_q.dqm;
        sram_wdata_q <= slot_q.wdata;
        sram_we_q    <= m4_cmd_cycle & slot_valid_q & ~m4_cmd_cycle_stp;
      end
    end
  end

  assign sram_wad      = sram_wad_q;
  assign sram_wr_bank1 = sram_bank1_q;
  assign sram_we       = sram_we_q;
  assign sram_dqm      = sram_dqm_q;
  assign sram_wdata    = sram_wdata_q;
  assign clr_busy      = (state_q == CLEAR) | (state_q == SWITCH);

`ifdef M4_WMUX_STALL_CNT_EN
  logic [7:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else if (req_valid && !req_ready && stall_cnt_q != 8'hFF) stall_cnt_q <= stall_cnt_q + 8'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/m4_mem_wmux_xt.md
Name: m4_mem_wmux_xt

Overview:
- Write-path merge stage directly downstream of the M4 SRAM clear write controller.
- During power-up clear, it forwards the clear controller's write stream to the SRAM write port.
- Meanwhile, normal write requests are buffered in a small FIFO and held off.
- After clear completes, it drains buffered and new normal writes, at most one per M4 command cycle, through a registered SRAM write interface.

Parameters:
- FIFO_DEPTH, 4, normal-write buffer entries; power of two, minimum 2.
- AW, 19, SRAM word address width.
- DW, 32, SRAM data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- m4_cmd_cycle_stp  in  1  one-clk pulse marking the start of each M4 command slot.
- m4_cmd_cycle  in  1  write-phase window within the slot.
- clr_wad  in  AW  clear-controller address.
- clr_wr_bank1  in  1  clear-controller bank select.
- clr_we  in  1  clear-controller write enable; already registered upstream.
- clr_dqm  in  4  clear-controller byte mask.
- clr_wdata  in  DW  clear-controller write data.
- mem_clear_done  in  1  clear complete; level signal.
- req_valid  in  1  normal write request.
- req_ready  out  1  high when the FIFO is not full; a push occurs on req_valid & req_ready.
- req_wad  in  AW  normal write address.
- req_bank1  in  1  normal write bank select.
- req_dqm  in  4  normal write byte mask.
- req_wdata  in  DW  normal write data.
- sram_wad  out  AW  SRAM address.
- sram_wr_bank1  out  1  SRAM bank select.
- sram_we  out  1  SRAM write enable.
- sram_dqm  out  4  SRAM byte mask.
- sram_wdata  out  DW  SRAM write data.
- clr_busy  out  1  high in states CLEAR and SWITCH.

Behaviour:
- Reset values:
  - All sram_* outputs 0; sram_dqm = 4'hF.
  - State CLEAR; FIFO empty; slot register invalid; req_ready 1; clr_busy 1.
- FSM:
  - CLEAR: on mem_clear_done = 1, go to SWITCH.
  - SWITCH: one guard slot; on the next m4_cmd_cycle_stp, go to NORMAL.
  - NORMAL: if mem_clear_done drops to 0 in SWITCH or NORMAL, return to CLEAR immediately.
- CLEAR output path:
  - sram_* <= clr_* every clk, giving one-clk latency.
  - Relative timing between clr_we and clr_wad is preserved unchanged.
- SWITCH output path: sram_we = 0; sram_dqm = 4'hF; address and data hold.
- NORMAL slot load:
  - On m4_cmd_cycle_stp, if the FIFO is non-empty, pop the head into the slot register and set slot_valid.
  - Otherwise clear slot_valid.
  - The pop and slot load happen on the same clk.
- NORMAL outputs:
  - sram_wad, sram_wr_bank1, sram_dqm and sram_wdata are driven from the slot register, registered.
  - sram_we <= m4_cmd_cycle & slot_valid & ~m4_cmd_cycle_stp.
- Ordering: at most one normal write per slot; writes leave in FIFO order.
- FIFO push:
  - Pushes are accepted in every state.
  - Simultaneous push and pop is allowed when full: the pop frees a slot the same clk, but req_ready is computed from the registered count, so no push occurs when full.
  - Push while empty with a same-clk stp: the entry is not visible until the next slot, so there is no bypass.
- Return to CLEAR: the slot register is invalidated and any in-flight normal write is abandoned. FIFO contents are retained.
- Pointers wrap modulo FIFO_DEPTH; the count is log2(FIFO_DEPTH)+1 bits wide.
- rst asserted mid-operation: FIFO contents discarded; all reset values applied next clk.

Optional Feature:
- Macro: M4_WMUX_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [7:0], a saturating count of clks with req_valid & ~req_ready.
  - Cleared by rst; holds at 8'hFF.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package m4_mem_pkg holds:
  - State encoding: CLEAR = 2'd0, SWITCH = 2'd1, NORMAL = 2'd2.
  - Constants M4_AW = 19, M4_DW = 32, DQM_NONE = 4'hF.
  - A packed write-entry typedef: {bank1, wad, dqm, wdata}.
- One sub-module, m4_wfifo_xt:
  - Synchronous FIFO of write entries with push, pop, full, empty and count.
  - Register-based, with no RAM macro.

Test Plan:
- Clear pass-through:
  - Stimulus: mem_clear_done = 0; clr_we = 1, clr_wad = 19'h00010, clr_wdata = 0.
  - Required: sram_we = 1 and sram_wad = 19'h00010 exactly one clk later; req pushes give no sram_we.
- Clear completion with buffered writes:
  - Stimulus: push 3 writes (wad 1, 2, 3; data A, B, C) during CLEAR; raise mem_clear_done.
  - Required: first slot after the guard slot writes wad 1 / data A; the next two slots write 2/B and 3/C; one sram_we burst per slot.
- Backpressure:
  - Stimulus: FIFO_DEPTH = 4; push 5 in CLEAR.
  - Required: req_ready = 0 after the 4th push; the 5th is held until NORMAL frees an entry; none lost, order kept.
- Clear restart:
  - Stimulus: in NORMAL with 2 entries queued, drop mem_clear_done.
  - Required: next clk sram_* follow clr_*, the slot is invalidated, the FIFO still holds 2; after re-done, both are written.
- Reset mid-drain:
  - Stimulus: rst = 1 for 1 clk with 3 entries queued.
  - Required: sram_we = 0, sram_dqm = 4'hF, req_ready = 1, clr_busy = 1; no stale write afterwards.
- Stall counter (M4_WMUX_STALL_CNT_EN defined):
  - Stimulus: hold req_valid high with the FIFO full for 300 clks.
  - Required: stall_cnt = 8'hFF, saturated.
